// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
interface rr_arbiter4_if;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  modport master (
    output req, done,
    input  grant, grant_idx, grant_valid, timeout
  );

  modport slave (
    input  req, done,
    output grant, grant_idx, grant_valid, timeout
  );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with a hold limit and one forced idle cycle per release.
//   state | meaning
//   IDLE  | no owner; pick first requester at or after ptr_q
//   BUSY  | owner grant_idx_q holds the resource until done, req drop or MAX_HOLD
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  rr_arbiter4_if.slave  arb_if
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q;
  logic [3:0]        grant_q;
  logic [1:0]        grant_idx_q;
  logic              grant_valid_q;
  logic              timeout_q;
  logic [1:0]        ptr_q;
  logic [HOLD_W-1:0] hold_q;

  logic [1:0] win_idx_d;
  logic       win_vld_d;
  logic [1:0] cand;
  logic       own_req;
  logic       own_done;
  logic       at_limit;

  // Scan offsets high to low so the lowest offset from ptr_q wins.
  always_comb begin
    win_idx_d = ptr_q;
    win_vld_d = 1'b0;
    cand      = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (arb_if.req[cand]) begin
        win_idx_d = cand;
        win_vld_d = 1'b1;
      end
    end
  end

  assign own_req  = arb_if.req[grant_idx_q];
  assign own_done = arb_if.done[grant_idx_q];
  assign at_limit = (hold_q == HOLD_W'(MAX_HOLD));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      grant_q       <= 4'b0000;
      grant_idx_q   <= 2'b00;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      ptr_q         <= 2'b00;
      hold_q        <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_vld_d) begin
            grant_q       <= 4'b0001 << win_idx_d;
            grant_idx_q   <= win_idx_d;
            grant_valid_q <= 1'b1;
            hold_q        <= HOLD_W'(1);
            state_q       <= BUSY;
          end
        end
        BUSY: begin
          if (own_done || !own_req || at_limit) begin
            grant_q       <= 4'b0000;
            grant_valid_q <= 1'b0;
            ptr_q         <= grant_idx_q + 2'd1;
            hold_q        <= '0;
            // A forced release only counts when the owner gave no release of its own.
            timeout_q     <= at_limit && !own_done && own_req;
            state_q       <= IDLE;
          end else begin
            hold_q <= at_limit ? hold_q : hold_q + HOLD_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign arb_if.grant       = grant_q;
  assign arb_if.grant_idx   = grant_idx_q;
  assign arb_if.grant_valid = grant_valid_q;
  assign arb_if.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed scoreboard bench for rr_arbiter4: expected grants queued by stimulus, checked by a monitor.
module tb_rr_arbiter4;
  localparam int MAXH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_arbiter4_if bus();

  rr_arbiter4 #(.MAX_HOLD(MAXH), .HOLD_W(5)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .arb_if (bus)
  );

  typedef struct {
    logic [3:0] grant;
    logic [1:0] idx;
    int         len;
    logic       to;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  bit   mon_en  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input logic [3:0] g, input logic [1:0] i, input int len,
                              input logic to, input int gap);
    exp_t e;
    e.grant = g; e.idx = i; e.len = len; e.to = to; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_grant"}, bus.grant, 0);
    chk({tag, "_idx"}, bus.grant_idx, 0);
    chk({tag, "_valid"}, bus.grant_valid, 0);
    chk({tag, "_timeout"}, bus.timeout, 0);
  endtask

  // Monitor: pops an expectation on each grant rise, checks length/timeout on its fall.
  initial begin
    exp_t cur;
    bit   have;
    int   len;
    int   idle;
    logic pv;
    have = 1'b0; len = 0; idle = 0; pv = 1'b0;
    wait (mon_en);
    forever begin
      @(negedge clk);
      chk("inv_onehot", int'($onehot0(bus.grant)), 1);
      chk("inv_valid_or", bus.grant_valid, |bus.grant);
      if (bus.grant_valid) chk("inv_idx", bus.grant[bus.grant_idx], 1);
      if (bus.grant_valid && !pv) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", bus.grant, 0);
          have = 1'b0;
        end else begin
          cur  = exp_q.pop_front();
          have = 1'b1;
          chk("grant", bus.grant, cur.grant);
          chk("grant_idx", bus.grant_idx, cur.idx);
          if (cur.gap >= 0) chk("idle_gap", idle, cur.gap);
        end
        len  = 1;
        idle = 0;
      end else if (bus.grant_valid) begin
        len++;
      end else if (pv) begin
        if (have) begin
          chk("hold_len", len, cur.len);
          chk("timeout", bus.timeout, cur.to);
        end
        have = 1'b0;
        idle = 1;
      end else begin
        chk("timeout_idle", bus.timeout, 0);
        idle++;
      end
      pv = bus.grant_valid;
    end
  end

  initial begin
    rst      = 1'b1;
    bus.req  = 4'b0000;
    bus.done = 4'b0000;
    tick();
    tick();
    chk_zero("reset");
    rst    = 1'b0;
    mon_en = 1'b1;

    // Single requester, released by its done strobe; ptr moves to 3.
    expect_grant(4'b0100, 2'd2, 2, 1'b0, -1);
    bus.req = 4'b0100;
    tick();
    chk("latency_grant", bus.grant, 4'b0100);
    tick();
    bus.done = 4'b0100;
    tick();
    bus.done = 4'b0000;
    bus.req  = 4'b1111;

    // Fairness rotation starting from ptr=3, one idle cycle between grants.
    expect_grant(4'b1000, 2'd3, 2, 1'b0, 1);
    expect_grant(4'b0001, 2'd0, 2, 1'b0, 1);
    expect_grant(4'b0010, 2'd1, 2, 1'b0, 1);
    expect_grant(4'b0100, 2'd2, 2, 1'b0, 1);
    expect_grant(4'b1000, 2'd3, 2, 1'b0, 1);
    expect_grant(4'b0001, 2'd0, 1, 1'b0, 1);
    tick();
    for (int n = 0; n < 5; n++) begin
      tick();
      bus.done = 4'b0001 << ((3 + n) % 4);
      tick();
      bus.done = 4'b0000;
      tick();
    end
    bus.req = 4'b0000;
    tick();

    // Hold limit: forced release with timeout, then regrant, then done at the limit.
    expect_grant(4'b0001, 2'd0, MAXH, 1'b1, 1);
    expect_grant(4'b0001, 2'd0, MAXH, 1'b0, 1);
    bus.req = 4'b0001;
    repeat (MAXH + 2) tick();
    repeat (MAXH - 1) tick();
    bus.done = 4'b0001;
    tick();
    bus.done = 4'b0000;
    bus.req  = 4'b0010;

    // Owner drops request; a stray done from a non-owner is ignored.
    expect_grant(4'b0010, 2'd1, 2, 1'b0, 1);
    tick();
    bus.done = 4'b1000;
    tick();
    bus.done = 4'b0000;
    bus.req  = 4'b0000;
    tick();

    // Reset mid-grant clears everything, including the pointer.
    expect_grant(4'b1000, 2'd3, 2, 1'b0, 1);
    expect_grant(4'b0001, 2'd0, 1, 1'b0, 1);
    bus.req = 4'b1000;
    tick();
    tick();
    rst     = 1'b1;
    bus.req = 4'b1001;
    tick();
    chk_zero("midreset");
    rst = 1'b0;
    tick();
    chk("post_reset_grant", bus.grant, 4'b0001);
    bus.req = 4'b0000;
    repeat (3) tick();

    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
